// File: rtl/sha_maj_pkg.sv
// Shared types and constants for the masked SHA-2 Maj round sequencer.
package sha_maj_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StWaitRnd,
        StIssue0,
        StIssue1,
        StCapture,
        StOut,
        StWaitA,
        StDone
    } state_e;

    localparam logic [31:0] Sha256K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] Sha512K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // Random bits consumed per bit by one HPC2 AND gadget.
    function automatic int unsigned nrnd(input int unsigned shares);
        return shares * (shares - 1) / 2;
    endfunction

endpackage

// File: rtl/sha_maj_state_regs.sv
// Three-deep masked shift register holding the working variables a, b, c.
module sha_maj_state_regs
    import sha_maj_pkg::*;
#(
    parameter int unsigned Width = 26
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_shift,
    input  logic             i_zero,
    input  logic [Width-1:0] i_din,
    output logic [Width-1:0] o_a,
    output logic [Width-1:0] o_b,
    output logic [Width-1:0] o_c
);

    logic [Width-1:0] r_a;
    logic [Width-1:0] r_b;
    logic [Width-1:0] r_c;

    // Zeroize wins over shift so no share survives the end of a block.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else if (i_zero) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else if (i_shift) begin
            r_c <= r_b;
            r_b <= r_a;
            r_a <= i_din;
        end
    end

    assign o_a = r_a;
    assign o_b = r_b;
    assign o_c = r_c;

endmodule

// File: rtl/sha_maj_sequencer.sv
// Round sequencer for the masked Maj path: holds a, b, c shares, feeds the external
// Maj gadget with fresh randomness each round and hands the result downstream.
module sha_maj_sequencer
    import sha_maj_pkg::*;
#(
    parameter int unsigned  d      = 2,
    parameter int unsigned  word   = 13,
    parameter int unsigned  ROUNDS = 64,
    localparam int unsigned NRND   = nrnd(d),
    localparam int unsigned W      = d * word,
    localparam int unsigned RW     = 2 * NRND * word
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [W-1:0]  i_in_a,
    input  logic          i_rnd_valid,
    output logic          o_rnd_ready,
    input  logic [RW-1:0] i_rnd_in,
    output logic [W-1:0]  o_maj_a,
    output logic [W-1:0]  o_maj_b,
    output logic [W-1:0]  o_maj_c,
    output logic [RW-1:0] o_maj_rnd,
    input  logic [W-1:0]  i_maj_res,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [W-1:0]  o_out_ma
);

    localparam int unsigned CW = $clog2(ROUNDS + 1);

    state_e        r_state;
    state_e        w_state_d;
    logic [1:0]    r_ld_cnt;
    logic [1:0]    w_ld_cnt_d;
    logic [CW-1:0] r_round;
    logic [CW-1:0] w_round_d;
    logic [CW-1:0] w_round_inc;
    logic [RW-1:0] r_rnd;
    logic [RW-1:0] w_rnd_d;
    logic [W-1:0]  r_out;
    logic [W-1:0]  w_out_d;
    logic          w_shift;
    logic          w_zero;
    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic [W-1:0]  w_c;

    sha_maj_state_regs #(
        .Width (W)
    ) u_state_regs (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_shift (w_shift),
        .i_zero  (w_zero),
        .i_din   (i_in_a),
        .o_a     (w_a),
        .o_b     (w_b),
        .o_c     (w_c)
    );

    assign w_round_inc = r_round + CW'(1);

    always_comb begin
        w_state_d   = r_state;
        w_ld_cnt_d  = r_ld_cnt;
        w_round_d   = r_round;
        w_rnd_d     = r_rnd;
        w_out_d     = r_out;
        w_shift     = 1'b0;
        w_zero      = 1'b0;
        o_busy      = (r_state != StIdle);
        o_done      = 1'b0;
        o_in_ready  = 1'b0;
        o_rnd_ready = 1'b0;
        o_out_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_ld_cnt_d = '0;
                w_round_d  = '0;
                if (i_start) w_state_d = StLoad;
            end
            StLoad: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_shift    = 1'b1;
                    w_ld_cnt_d = r_ld_cnt + 2'd1;
                    if (r_ld_cnt == 2'd2) w_state_d = StWaitRnd;
                end
            end
            StWaitRnd: begin
                o_rnd_ready = 1'b1;
                if (i_rnd_valid) begin
                    w_rnd_d   = i_rnd_in;
                    w_state_d = StIssue0;
                end
            end
            StIssue0:  w_state_d = StIssue1;
            StIssue1:  w_state_d = StCapture;
            StCapture: begin
                // Randomness is consumed exactly once; wipe it as the result lands.
                w_out_d   = i_maj_res;
                w_rnd_d   = '0;
                w_state_d = StOut;
            end
            StOut: begin
                o_out_valid = 1'b1;
                if (i_out_ready) w_state_d = StWaitA;
            end
            StWaitA: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_shift   = 1'b1;
                    w_round_d = w_round_inc;
                    w_state_d = (w_round_inc == CW'(ROUNDS)) ? StDone : StWaitRnd;
                end
            end
            StDone: begin
                o_done    = 1'b1;
                w_zero    = 1'b1;
                w_out_d   = '0;
                w_rnd_d   = '0;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_ld_cnt <= '0;
            r_round  <= '0;
            r_rnd    <= '0;
            r_out    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_ld_cnt <= w_ld_cnt_d;
            r_round  <= w_round_d;
            r_rnd    <= w_rnd_d;
            r_out    <= w_out_d;
        end
    end

    assign o_maj_a   = w_a;
    assign o_maj_b   = w_b;
    assign o_maj_c   = w_c;
    assign o_maj_rnd = r_rnd;
    assign o_out_ma  = r_out;

endmodule

// File: tb/tb_sha_maj_sequencer.sv
// Scoreboard bench for sha_maj_sequencer with a 2-cycle masked Maj gadget model.
module tb_sha_maj_sequencer;

    localparam int unsigned ROUNDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] in_a;
    logic        rnd_valid;
    logic        rnd_ready;
    logic [25:0] rnd_in;
    logic [25:0] maj_a;
    logic [25:0] maj_b;
    logic [25:0] maj_c;
    logic [25:0] maj_rnd;
    logic [25:0] maj_res;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_ma;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_rnd_cyc = -100;
    int          rnd_hs_cnt = 0;
    int          out_hs_cnt = 0;
    int          done_cnt = 0;
    int          in_hs_cyc = 0;
    logic [25:0] hs_rnd = '0;
    logic [12:0] m_a = '0;
    logic [12:0] m_b = '0;
    logic [12:0] m_c = '0;
    logic [12:0] exp_q[$];
    bit          bp_req = 1'b1;
    bit          stall_req = 1'b1;
    logic        prev_ov = 1'b0;
    logic        prev_or = 1'b0;
    logic [25:0] prev_ma = '0;
    logic [25:0] g1 = '0;
    logic [25:0] g2 = '0;

    sha_maj_sequencer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_rnd_valid (rnd_valid),
        .o_rnd_ready (rnd_ready),
        .i_rnd_in    (rnd_in),
        .o_maj_a     (maj_a),
        .o_maj_b     (maj_b),
        .o_maj_c     (maj_c),
        .o_maj_rnd   (maj_rnd),
        .i_maj_res   (maj_res),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_ma    (out_ma)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] maj(input logic [12:0] x, input logic [12:0] y,
                                        input logic [12:0] z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic [25:0] mask(input logic [12:0] v, input logic [12:0] m);
        logic [25:0] s;
        for (int j = 0; j < 13; j++) begin
            s[2*j]   = v[j] ^ m[j];
            s[2*j+1] = m[j];
        end
        return s;
    endfunction

    function automatic logic [12:0] unmask(input logic [25:0] s);
        logic [12:0] v;
        for (int j = 0; j < 13; j++) v[j] = s[2*j] ^ s[2*j+1];
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Gadget model: result in cycle k is Maj of the operands seen in cycle k-2.
    initial begin
        maj_res = '0;
        forever begin
            @(posedge clk);
            #1;
            maj_res = g2;
            g2 = g1;
            g1 = mask(maj(unmask(maj_a), unmask(maj_b), unmask(maj_c)), maj_rnd[12:0]);
        end
    end

    initial begin
        rnd_in = '0;
        forever begin
            @(posedge clk);
            #1;
            rnd_in = 26'($urandom);
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (rnd_valid && rnd_ready) begin
                last_rnd_cyc = cyc;
                hs_rnd = rnd_in;
                rnd_hs_cnt++;
            end
            if (cyc == last_rnd_cyc + 1 || cyc == last_rnd_cyc + 2)
                check("issue_ops", 128'({unmask(maj_a), unmask(maj_b), unmask(maj_c), maj_rnd}),
                      128'({m_a, m_b, m_c, hs_rnd}));
            if (out_valid && !prev_ov)
                check("out_latency", 128'(cyc - last_rnd_cyc), 128'(4));
            if (out_valid)
                check("out_excl", 128'({in_ready, rnd_ready, maj_rnd}), 128'(0));
            if (out_valid && prev_ov && !prev_or)
                check("bp_hold", 128'(out_ma), 128'(prev_ma));
            if (out_valid && out_ready) begin
                out_hs_cnt++;
                if (exp_q.size() == 0) check("spurious_out", 128'(out_valid), 128'(0));
                else check("out_ma", 128'(unmask(out_ma)), 128'(exp_q.pop_front()));
            end
            if (done) done_cnt++;
        end
        prev_ov = out_valid;
        prev_or = out_ready;
        prev_ma = out_ma;
    end

    // Back-pressure on the second result of the first block.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_req && out_valid && out_hs_cnt == 1) begin
                bp_req = 1'b0;
                out_ready = 1'b0;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        end
    end

    // Randomness stall ahead of the third round of the first block.
    initial begin
        int n;
        int rise;
        rnd_valid = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req && out_valid && out_hs_cnt == 2) begin
                stall_req = 1'b0;
                rnd_valid = 1'b0;
                n = 0;
                while (!rnd_ready && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("stall_wait", 128'(rnd_ready), 128'(1));
                for (int i = 0; i < 5; i++) begin
                    check("stall_rnd_zero", 128'({rnd_ready, maj_rnd}), 128'({1'b1, 26'd0}));
                    @(posedge clk);
                    #1;
                end
                rnd_valid = 1'b1;
                rise = cyc;
                @(negedge clk);
                #1;
                check("stall_hs_cyc", 128'(last_rnd_cyc), 128'(rise));
            end
        end
    end

    task automatic send_word(input logic [12:0] v);
        int n;
        n = 0;
        in_a = mask(v, 13'($urandom));
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("in_hs", 128'(in_ready), 128'(1));
        if (in_ready) begin
            in_hs_cyc = cyc;
            m_c = m_b;
            m_b = m_a;
            m_a = v;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ctl"}, 128'({busy, done, in_ready, rnd_ready, out_valid, maj_rnd}), 128'(0));
        check({tag, "_data"}, 128'({out_ma, maj_a, maj_b, maj_c}), 128'(0));
    endtask

    // Words go in oldest first, so the third word ends up in register a.
    task automatic run_block(input int abort_at, input logic [12:0] w0, input logic [12:0] w1,
                             input logic [12:0] w2, input logic [12:0] na, input bit hand);
        int   ob;
        int   db;
        int   n;
        int   tgt;
        logic seen;
        ob = out_hs_cnt;
        db = done_cnt;
        exp_q.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_rise", 128'({busy, in_ready}), 128'(2'b11));
        send_word(w0);
        send_word(w1);
        send_word(w2);
        exp_q.push_back(hand ? 13'h0FF0 : maj(m_a, m_b, m_c));
        for (int r = 0; r < ROUNDS; r++) begin
            if (r == abort_at) begin
                tgt = rnd_hs_cnt + 1;
                n = 0;
                while (rnd_hs_cnt < tgt && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                @(posedge clk);
                #2;
                rst = 1'b1;
                #1;
                check_cleared("abort");
                exp_q.delete();
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                seen = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    seen = seen | out_valid | busy;
                end
                check("post_abort_quiet", 128'(seen), 128'(0));
                return;
            end
            send_word(r == 0 ? na : 13'($urandom));
            if (r < ROUNDS - 1)
                exp_q.push_back((hand && r == 0) ? 13'h1F50 : maj(m_a, m_b, m_c));
        end
        @(negedge clk);
        check("done_pulse", 128'({done, busy}), 128'(2'b11));
        check("done_cyc", 128'(cyc - in_hs_cyc), 128'(1));
        @(negedge clk);
        check_cleared("post_done");
        check("out_count", 128'(out_hs_cnt - ob), 128'(ROUNDS));
        check("done_count", 128'(done_cnt - db), 128'(1));
        check("q_drained", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_block(-1, 13'h00FF, 13'h0FF0, 13'h1F00, 13'h1555, 1'b1);
        run_block(10, 13'($urandom), 13'($urandom), 13'($urandom), 13'($urandom), 1'b0);
        run_block(-1, 13'($urandom), 13'($urandom), 13'($urandom), 13'($urandom), 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: run did not finish, %0d miscompares so far", n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
